// File: rtl/simple_risc_pkg.sv
// rtl/simple_risc_pkg.sv - SimpleRISC shared types and constants for pipeline control
package simple_risc_pkg;

    localparam int          REG_W  = 4;
    localparam logic [3:0]  RA_REG = 4'd15;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef struct packed {
        logic             v;
        logic             wen;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        EX_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracking for EX/MA/WB and RAW compare
module hazard_scoreboard
    import simple_risc_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold_ex,
    input  logic             ins_bubble,
    input  logic             of_valid,
    input  logic             of_wen,
    input  logic [REG_W-1:0] of_rd,
    input  logic [REG_W-1:0] of_rs1,
    input  logic [REG_W-1:0] of_rs2,
    input  logic             of_use_rs1,
    input  logic             of_use_rs2,
    output logic             raw_hit
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t ma_q, ma_d;
    sb_entry_t wb_q, wb_d;

    function automatic logic src_match(input sb_entry_t e);
        return e.v && e.wen &&
               ((of_use_rs1 && (e.rd == of_rs1)) || (of_use_rs2 && (e.rd == of_rs2)));
    endfunction

    always_comb begin
        wb_d = ma_q;
        ma_d = ex_q;
        ex_d = ex_q;
        if (hold_ex) begin
            // long op stays in EX; a bubble drains into MA behind it
            ma_d = '0;
        end else if (ins_bubble) begin
            ex_d = '0;
        end else begin
            ex_d.v   = of_valid;
            ex_d.wen = of_wen;
            ex_d.rd  = of_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q <= '0;
            ma_q <= '0;
            wb_q <= '0;
        end else begin
            ex_q <= ex_d;
            ma_q <= ma_d;
            wb_q <= wb_d;
        end
    end

    always_comb begin
        raw_hit = of_valid &&
                  (src_match(ex_q) || src_match(ma_q) ||
                   ((WB_BYPASS == 0) && src_match(wb_q)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage enable/clear sequencing for RAW, flush and long EX ops
module pipe_hazard_ctrl
    import simple_risc_pkg::*;
#(
    parameter int DIV_LATENCY = 8,
    parameter int WB_BYPASS   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             of_valid,
    input  logic [3:0]       of_rs1,
    input  logic [3:0]       of_rs2,
    input  logic             of_use_rs1,
    input  logic             of_use_rs2,
    input  logic             of_wen,
    input  logic [3:0]       of_rd,
    input  logic             of_is_long,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             if_of_clr,
    output logic             of_ex_en,
    output logic             of_ex_clr,
    output logic             ex_ma_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int LW = $clog2(DIV_LATENCY + 1);

    hz_state_t        state_q, state_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             hold_ex, ins_bubble, raw_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .hold_ex    (hold_ex),
        .ins_bubble (ins_bubble),
        .of_valid   (of_valid),
        .of_wen     (of_wen),
        .of_rd      (of_rd),
        .of_rs1     (of_rs1),
        .of_rs2     (of_rs2),
        .of_use_rs1 (of_use_rs1),
        .of_use_rs2 (of_use_rs2),
        .raw_hit    (raw_hit)
    );

    always_comb begin
        state_d    = state_q;
        lcnt_d     = lcnt_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        pc_en      = 1'b1;
        if_of_clr  = 1'b0;
        of_ex_en   = 1'b1;
        of_ex_clr  = 1'b0;
        ex_ma_clr  = 1'b0;
        hold_ex    = 1'b0;
        ins_bubble = 1'b0;
        // while reset is held the strobes stay at their pass-through values
        if (reset) begin
            case (state_q)
                EX_WAIT: begin
                    pc_en     = 1'b0;
                    of_ex_en  = 1'b0;
                    ex_ma_clr = 1'b1;
                    hold_ex   = 1'b1;
                    stall_d   = sat_inc(stall_q);
                    lcnt_d    = lcnt_q - 1'b1;
                    if (lcnt_q == LW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (ex_branch_taken) begin
                        if_of_clr  = 1'b1;
                        of_ex_clr  = 1'b1;
                        ins_bubble = 1'b1;
                        flush_d    = sat_inc(flush_q);
                    end else if (raw_hit) begin
                        pc_en      = 1'b0;
                        of_ex_clr  = 1'b1;
                        ins_bubble = 1'b1;
                        stall_d    = sat_inc(stall_q);
                    end else if (of_valid && of_is_long) begin
                        state_d = EX_WAIT;
                        lcnt_d  = LW'(DIV_LATENCY - 1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            lcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - two configurations of pipe_hazard_ctrl against a pipeline occupancy model
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       of_valid = 1'b0;
    logic [3:0] of_rs1 = '0;
    logic [3:0] of_rs2 = '0;
    logic [3:0] of_rd = '0;
    logic       of_use_rs1 = 1'b0;
    logic       of_use_rs2 = 1'b0;
    logic       of_wen = 1'b0;
    logic       of_is_long = 1'b0;
    logic       ex_branch_taken = 1'b0;

    logic        pc_en_a, if_of_clr_a, of_ex_en_a, of_ex_clr_a, ex_ma_clr_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        pc_en_b, if_of_clr_b, of_ex_en_b, of_ex_clr_b, ex_ma_clr_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_LATENCY(8), .WB_BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2), .of_wen(of_wen), .of_rd(of_rd),
        .of_is_long(of_is_long), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en_a), .if_of_clr(if_of_clr_a), .of_ex_en(of_ex_en_a), .of_ex_clr(of_ex_clr_a),
        .ex_ma_clr(ex_ma_clr_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipe_hazard_ctrl #(.DIV_LATENCY(2), .WB_BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2), .of_wen(of_wen), .of_rd(of_rd),
        .of_is_long(of_is_long), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en_b), .if_of_clr(if_of_clr_b), .of_ex_en(of_ex_en_b), .of_ex_clr(of_ex_clr_b),
        .ex_ma_clr(ex_ma_clr_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    localparam int M_RST = 0, M_WAIT = 1, M_FLUSH = 2, M_STALL = 3, M_GO = 4;

    // pend[k][0..2]: register written by the instruction in EX/MA/WB, -1 if none
    int pend [2][3];
    int busy [2];
    int scnt [2];
    int fcnt [2];
    int n_cmp = 0;
    int n_err = 0;
    logic last_pc_a, last_ifc_a, last_ofc_a;
    int acc_exc_a, acc_pcl_a, acc_exc_b;

    function automatic int cmax(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic int dlat(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    function automatic bit reads(input int r);
        return (r >= 0) && ((of_use_rs1 && r == int'(of_rs1)) || (of_use_rs2 && r == int'(of_rs2)));
    endfunction

    function automatic bit dep(input int k);
        if (!of_valid) return 1'b0;
        return reads(pend[k][0]) || reads(pend[k][1]) || ((k == 1) && reads(pend[k][2]));
    endfunction

    function automatic int mode(input int k);
        if (!reset) return M_RST;
        if (busy[k] > 0) return M_WAIT;
        if (ex_branch_taken) return M_FLUSH;
        if (dep(k)) return M_STALL;
        return M_GO;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int k, input int m);
        logic [4:0] e;
        logic [4:0] o;
        string p;
        case (m)
            M_WAIT:  e = 5'b00001;
            M_FLUSH: e = 5'b11110;
            M_STALL: e = 5'b00110;
            default: e = 5'b10100;
        endcase
        o = (k == 0) ? {pc_en_a, if_of_clr_a, of_ex_en_a, of_ex_clr_a, ex_ma_clr_a}
                     : {pc_en_b, if_of_clr_b, of_ex_en_b, of_ex_clr_b, ex_ma_clr_b};
        p = (k == 0) ? "a" : "b";
        check({p, ".pc_en"},     32'(o[4]), 32'(e[4]));
        check({p, ".if_of_clr"}, 32'(o[3]), 32'(e[3]));
        check({p, ".of_ex_en"},  32'(o[2]), 32'(e[2]));
        check({p, ".of_ex_clr"}, 32'(o[1]), 32'(e[1]));
        check({p, ".ex_ma_clr"}, 32'(o[0]), 32'(e[0]));
        check({p, ".stall_cnt"}, (k == 0) ? 32'(stall_cnt_a) : 32'(stall_cnt_b), 32'(scnt[k]));
        check({p, ".flush_cnt"}, (k == 0) ? 32'(flush_cnt_a) : 32'(flush_cnt_b), 32'(fcnt[k]));
    endtask

    task automatic model_step(input int k, input int m);
        case (m)
            M_RST: begin
                for (int s = 0; s < 3; s++) pend[k][s] = -1;
                busy[k] = 0;
                scnt[k] = 0;
                fcnt[k] = 0;
            end
            M_WAIT: begin
                pend[k][2] = pend[k][1];
                pend[k][1] = -1;
                busy[k]--;
                if (scnt[k] < cmax(k)) scnt[k]++;
            end
            default: begin
                pend[k][2] = pend[k][1];
                pend[k][1] = pend[k][0];
                pend[k][0] = -1;
                if (m == M_FLUSH && fcnt[k] < cmax(k)) fcnt[k]++;
                if (m == M_STALL && scnt[k] < cmax(k)) scnt[k]++;
                if (m == M_GO) begin
                    if (of_valid && of_wen) pend[k][0] = int'(of_rd);
                    if (of_valid && of_is_long) busy[k] = dlat(k) - 1;
                end
            end
        endcase
    endtask

    task automatic drive(input bit rst, input bit v, input int rs1, input bit u1,
                         input int rs2, input bit u2, input bit w, input int rd,
                         input bit lg, input bit br);
        int m0, m1;
        reset = rst;
        of_valid = v;
        of_rs1 = 4'(rs1);
        of_use_rs1 = u1;
        of_rs2 = 4'(rs2);
        of_use_rs2 = u2;
        of_wen = w;
        of_rd = 4'(rd);
        of_is_long = lg;
        ex_branch_taken = br;
        @(negedge clk);
        m0 = mode(0);
        m1 = mode(1);
        check_outs(0, m0);
        check_outs(1, m1);
        last_pc_a = pc_en_a;
        last_ifc_a = if_of_clr_a;
        last_ofc_a = of_ex_clr_a;
        acc_exc_a += int'(ex_ma_clr_a);
        acc_pcl_a += int'(!pc_en_a);
        acc_exc_b += int'(ex_ma_clr_b);
        @(posedge clk);
        model_step(0, m0);
        model_step(1, m1);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic producer(input int rd);
        drive(1, 1, 0, 0, 0, 0, 1, rd, 0, 0);
    endtask

    task automatic consumer(input int rs1, input bit w, input int rd, input bit br);
        drive(1, 1, rs1, 1, 0, 0, w, rd, 0, br);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) pend[k][s] = -1;
            busy[k] = 0;
            scnt[k] = 0;
            fcnt[k] = 0;
        end

        // reset holds strobes at pass-through even with a taken branch present
        drive(0, 1, 1, 1, 2, 1, 1, 3, 0, 1);
        drive(0, 1, 1, 1, 2, 1, 1, 3, 0, 1);
        check("rst.pc_en", 32'(pc_en_a), 1);
        check("rst.if_of_clr", 32'(if_of_clr_a), 0);
        check("rst.stall_cnt", 32'(stall_cnt_a), 0);

        // back-to-back RAW on r1
        producer(1);
        repeat (4) consumer(1, 1, 2, 0);
        check("raw.stall_bypass", 32'(stall_cnt_a), 2);
        check("raw.stall_nobypass", 32'(stall_cnt_b), 3);

        // single taken branch
        do_reset();
        drive(1, 1, 5, 1, 0, 0, 1, 6, 0, 1);
        check("br.if_of_clr_hi", 32'(last_ifc_a), 1);
        check("br.of_ex_clr_hi", 32'(last_ofc_a), 1);
        drive(1, 1, 5, 1, 0, 0, 1, 6, 0, 0);
        check("br.if_of_clr_lo", 32'(last_ifc_a), 0);
        check("br.of_ex_clr_lo", 32'(last_ofc_a), 0);
        check("br.flush_cnt", 32'(flush_cnt_a), 1);

        // flush takes priority over a simultaneous interlock
        do_reset();
        producer(1);
        consumer(1, 1, 2, 1);
        check("fos.pc_en", 32'(last_pc_a), 1);
        check("fos.stall_cnt", 32'(stall_cnt_a), 0);
        check("fos.flush_cnt", 32'(flush_cnt_a), 1);

        // div r4 then an independent add
        do_reset();
        acc_exc_a = 0;
        acc_pcl_a = 0;
        acc_exc_b = 0;
        drive(1, 1, 0, 0, 0, 0, 1, 4, 1, 0);
        repeat (9) consumer(5, 1, 6, 0);
        check("div.ex_ma_clr_cycles", 32'(acc_exc_a), 7);
        check("div.pc_low_cycles", 32'(acc_pcl_a), 7);
        check("div.stall_cnt", 32'(stall_cnt_a), 7);
        check("div2.ex_ma_clr_cycles", 32'(acc_exc_b), 1);
        check("div2.stall_cnt", 32'(stall_cnt_b), 1);

        // div r4 then a consumer of r4
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 1, 4, 1, 0);
        repeat (12) consumer(4, 0, 0, 0);
        check("divdep.stall_cnt", 32'(stall_cnt_a), 9);
        check("divdep2.stall_cnt", 32'(stall_cnt_b), 4);

        // saturation of the narrow counter
        do_reset();
        repeat (8) begin
            producer(1);
            repeat (4) consumer(1, 1, 2, 0);
        end
        check("sat.stall_cnt16", 32'(stall_cnt_a), 16);
        check("sat.stall_cnt4", 32'(stall_cnt_b), 15);

        // reset in the middle of a long-op wait
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 1, 4, 1, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        consumer(4, 0, 0, 0);
        check("midrst.pc_en", 32'(last_pc_a), 1);
        check("midrst.of_ex_clr", 32'(last_ofc_a), 0);
        check("midrst.stall_cnt", 32'(stall_cnt_a), 0);

        // randomized traffic against the occupancy model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 4)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
